lookahead_iir_mc: RTL

- Parametrised, time-multiplexed successor to the fixed 7-tap / 2-feedback lookahead IIR filter.
- Implements y[n] = sum(b_i*x[n-i], i=0..NUM_FF-1) - sum(a_k*y[n-k*LOOKAHEAD], k=1..NUM_FB) for CHANNELS independent channels.
- One shared MAC is sequenced by an FSM. Coefficients are written through a register port and shared by all channels.
- Sits between the ADC sample interface and the DAC/output stage.

---
 rtl/lookahead_iir_pkg.sv | 41 ++++
 rtl/lookahead_iir_mc_mac.sv | 45 ++++
 rtl/lookahead_iir_mc.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lookahead_iir_pkg.sv
// Shared types, default configuration and saturation helpers for the
// time-multiplexed lookahead IIR filter.
package lookahead_iir_pkg;

    typedef enum logic [2:0] {IDLE, FF, FB, SAT, OUT} state_e;

    localparam int unsigned ADC_BITS_DEF   = 10;
    localparam int unsigned WHOLE_BITS_DEF = 10;
    localparam int unsigned FRAC_BITS_DEF  = 22;
    localparam int unsigned GUARD_BITS_DEF = 4;
    localparam int unsigned NUM_FF_DEF     = 7;
    localparam int unsigned NUM_FB_DEF     = 2;
    localparam int unsigned LOOKAHEAD_DEF  = 3;
    localparam int unsigned CHANNELS_DEF   = 2;

    localparam int unsigned ACC_W  = WHOLE_BITS_DEF + FRAC_BITS_DEF + GUARD_BITS_DEF;
    localparam int unsigned YDEPTH = NUM_FB_DEF * LOOKAHEAD_DEF;
    localparam int unsigned NCOEF  = NUM_FF_DEF + NUM_FB_DEF;

    // Clamp a sign-extended value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [63:0] sat_to_adc(input logic signed [63:0] v,
                                                      input int unsigned bits);
        return sat_to_width(v, bits);
    endfunction

endpackage

// File: rtl/lookahead_iir_mc_mac.sv
// Shared multiply-accumulate: product truncated to the accumulator grid and
// added to or subtracted from a wrapping accumulator register.
module iir_mac #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 22,
    parameter int unsigned ACC_W     = 36
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    sub_i,
    input  logic signed [WIDTH-1:0] coef_i,
    input  logic signed [WIDTH-1:0] data_i,
    output logic signed [ACC_W-1:0] acc_o
);
    localparam int unsigned PW = 2 * WIDTH;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        prod  = PW'(coef_i) * PW'(data_i);
        // Arithmetic shift then truncate gives floor rounding of the product.
        term  = ACC_W'(prod >>> FRAC_BITS);
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sub_i ? (acc_q - term) : (acc_q + term);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/lookahead_iir_mc.sv
// Multi-channel lookahead IIR filter: one MAC sequenced over the feedforward
// and feedback taps of each accepted sample, with shared coefficients.
module lookahead_iir_mc
    import lookahead_iir_pkg::*;
#(
    parameter int unsigned ADC_BITS   = ADC_BITS_DEF,
    parameter int unsigned WHOLE_BITS = WHOLE_BITS_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
    parameter int unsigned WIDTH      = WHOLE_BITS + FRAC_BITS,
    parameter int unsigned GUARD_BITS = GUARD_BITS_DEF,
    parameter int unsigned NUM_FF     = NUM_FF_DEF,
    parameter int unsigned NUM_FB     = NUM_FB_DEF,
    parameter int unsigned LOOKAHEAD  = LOOKAHEAD_DEF,
    parameter int unsigned CHANNELS   = CHANNELS_DEF,
    localparam int unsigned AW = $clog2(NUM_FF + NUM_FB),
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       coefficients_ready,
    input  logic                       coef_we,
    input  logic [AW-1:0]              coef_addr,
    input  logic signed [WIDTH-1:0]    coef_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CW-1:0]              in_ch,
    input  logic signed [ADC_BITS-1:0] in_data,
    output logic                       out_valid,
    output logic [CW-1:0]              out_ch,
    output logic signed [ADC_BITS-1:0] out_data,
    output logic                       out_sat,
    output logic                       in_ch_err
);
    localparam int unsigned AccW = WIDTH + GUARD_BITS;
    localparam int unsigned YDep = NUM_FB * LOOKAHEAD;
    localparam int unsigned NCf  = NUM_FF + NUM_FB;
    localparam int unsigned CntW = $clog2(NCf);

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic                       err_q, err_d;
    logic signed [WIDTH-1:0]    xnew_q, xnew_d;
    logic signed [WIDTH-1:0]    coef_q [NCf];
    logic signed [WIDTH-1:0]    coef_d [NCf];
    logic signed [WIDTH-1:0]    xh_q [CHANNELS][NUM_FF-1];
    logic signed [WIDTH-1:0]    xh_d [CHANNELS][NUM_FF-1];
    logic signed [WIDTH-1:0]    yh_q [CHANNELS][YDep];
    logic signed [WIDTH-1:0]    yh_d [CHANNELS][YDep];
    logic signed [ADC_BITS-1:0] out_data_q, out_data_d;
    logic [CW-1:0]              out_ch_q, out_ch_d;
    logic                       out_sat_q, out_sat_d;

    logic                       accept, mac_clear, mac_en, mac_sub;
    logic signed [WIDTH-1:0]    mac_a, mac_b, x_in, y_new;
    logic signed [AccW-1:0]     acc;
    logic signed [63:0]         acc_ext, y_wide, int_wide, o_wide;

    assign in_ready  = (state_q == IDLE) && coefficients_ready && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT) && !err_q;
    assign in_ch_err = (state_q == OUT) && err_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        x_in     = WIDTH'(in_data) <<< FRAC_BITS;
        acc_ext  = 64'(acc);
        y_wide   = sat_to_width(acc_ext, WIDTH);
        y_new    = WIDTH'(y_wide);
        int_wide = acc_ext >>> FRAC_BITS;
        o_wide   = sat_to_adc(int_wide, ADC_BITS);
    end

    // Tap operand selection for the current MAC step.
    always_comb begin
        mac_a   = '0;
        mac_b   = '0;
        mac_en  = 1'b0;
        mac_sub = 1'b0;
        if (state_q == FF) begin
            mac_en = 1'b1;
            for (int i = 0; i < NUM_FF; i++) begin
                if (int'(cnt_q) == i) mac_a = coef_q[i];
            end
            if (cnt_q == '0) begin
                mac_b = xnew_q;
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int i = 1; i < NUM_FF; i++) begin
                        if (int'(ch_q) == c && int'(cnt_q) == i) mac_b = xh_q[c][i-1];
                    end
                end
            end
        end else if (state_q == FB) begin
            mac_en  = 1'b1;
            mac_sub = 1'b1;
            for (int k = 0; k < NUM_FB; k++) begin
                if (int'(cnt_q) == k) begin
                    mac_a = coef_q[NUM_FF+k];
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (int'(ch_q) == c) mac_b = yh_q[c][(k+1)*LOOKAHEAD-1];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        err_d      = err_q;
        xnew_d     = xnew_q;
        coef_d     = coef_q;
        xh_d       = xh_q;
        yh_d       = yh_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_sat_d  = out_sat_q;
        mac_clear  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d  = in_ch;
                    cnt_d = '0;
                    if (int'(in_ch) < CHANNELS) begin
                        xnew_d    = x_in;
                        err_d     = 1'b0;
                        mac_clear = 1'b1;
                        state_d   = FF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = OUT;
                    end
                end
            end
            FF: begin
                if (cnt_q == CntW'(NUM_FF - 1)) begin
                    cnt_d   = '0;
                    state_d = FB;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            FB: begin
                if (cnt_q == CntW'(NUM_FB - 1)) begin
                    state_d = SAT;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            SAT: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (int'(ch_q) == c) begin
                        xh_d[c][0] = xnew_q;
                        for (int i = 1; i < NUM_FF - 1; i++) xh_d[c][i] = xh_q[c][i-1];
                        yh_d[c][0] = y_new;
                        for (int j = 1; j < YDep; j++) yh_d[c][j] = yh_q[c][j-1];
                    end
                end
                out_data_d = ADC_BITS'(o_wide);
                out_sat_d  = (o_wide != int_wide);
                out_ch_d   = ch_q;
                state_d    = OUT;
            end
            OUT: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Load mode overrides everything in flight.
        if (!coefficients_ready) begin
            state_d = IDLE;
            err_d   = 1'b0;
            xh_d    = '{default: '0};
            yh_d    = '{default: '0};
            for (int i = 0; i < NCf; i++) begin
                if (coef_we && int'(coef_addr) == i) coef_d[i] = coef_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            err_q      <= 1'b0;
            xnew_q     <= '0;
            coef_q     <= '{default: '0};
            xh_q       <= '{default: '0};
            yh_q       <= '{default: '0};
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            err_q      <= err_d;
            xnew_q     <= xnew_d;
            coef_q     <= coef_d;
            xh_q       <= xh_d;
            yh_q       <= yh_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_sat_q  <= out_sat_d;
        end
    end

    iir_mac #(
        .WIDTH    (WIDTH),
        .FRAC_BITS(FRAC_BITS),
        .ACC_W    (AccW)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear_i(mac_clear),
        .en_i   (mac_en),
        .sub_i  (mac_sub),
        .coef_i (mac_a),
        .data_i (mac_b),
        .acc_o  (acc)
    );

endmodule
